// File: rtl/logic_op_unit.sv
// Registered bitwise operation unit: eight ops applied per beat or folded over a packet.
// Optional result flags (OUT_ZERO/OUT_ONES/OUT_PARITY) are built when LOGIC_FLAGS_EN is defined.
module logic_op_unit #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  OP,
    input  logic             ACC,
    input  logic             IN_LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_LAST
`ifdef LOGIC_FLAGS_EN
    ,
    output logic             OUT_ZERO,
    output logic             OUT_ONES,
    output logic             OUT_PARITY
`endif
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic logic [WIDTH-1:0] apply_op(input logic [OP_W-1:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = x;
        unique case (op_e'(op))
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_ANDN: r = x & ~y;
            OP_PASS: r = x;
        endcase
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q;
    logic             out_last_q;
    logic             out_valid_q;

    logic             fire;
    logic             load;
    logic [WIDTH-1:0] res;
    logic             res_last;

    assign IN_READY  = !out_valid_q || OUT_READY;
    assign fire      = IN_VALID && IN_READY;
    assign OUT       = out_q;
    assign OUT_LAST  = out_last_q;
    assign OUT_VALID = out_valid_q;

    // The FSM state itself records accumulate mode; only the op needs latching per packet.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        load     = 1'b0;
        res      = '0;
        res_last = 1'b0;
        if (fire) begin
            unique case (state_q)
                IDLE: begin
                    res = apply_op(OP, A, B);
                    if (ACC) begin
                        op_d  = OP;
                        acc_d = res;
                        if (IN_LAST) begin
                            load     = 1'b1;
                            res_last = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        load     = 1'b1;
                        res_last = IN_LAST;
                    end
                end
                ACCUM: begin
                    res   = apply_op(op_q, acc_q, A);
                    acc_d = res;
                    if (IN_LAST) begin
                        load     = 1'b1;
                        res_last = 1'b1;
                        state_d  = IDLE;
                    end
                end
            endcase
        end
    end

`ifdef LOGIC_FLAGS_EN
    logic zero_q, ones_q, parity_q;
    assign OUT_ZERO   = zero_q;
    assign OUT_ONES   = ones_q;
    assign OUT_PARITY = parity_q;
`endif

    always_ff @(posedge CLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) begin
            state_q     <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef LOGIC_FLAGS_EN
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            // A new load wins over a simultaneous transfer, keeping OUT_VALID high.
            if (load) begin
                out_q       <= res;
                out_last_q  <= res_last;
                out_valid_q <= 1'b1;
`ifdef LOGIC_FLAGS_EN
                zero_q      <= (res == '0);
                ones_q      <= (res == '1);
                parity_q    <= ^res;
`endif
            end else if (OUT_READY) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed test-plan steps followed by randomized traffic checked against a packet-level model.
module tb_logic_op_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       acc;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       out_last;
`ifdef LOGIC_FLAGS_EN
    logic       out_zero, out_ones, out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    logic_op_unit #(.WIDTH(8), .OP_W(3)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .A         (a),
        .B         (b),
        .OP        (op),
        .ACC       (acc),
        .IN_LAST   (in_last),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT       (out),
        .OUT_LAST  (out_last)
`ifdef LOGIC_FLAGS_EN
        ,
        .OUT_ZERO  (out_zero),
        .OUT_ONES  (out_ones),
        .OUT_PARITY(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic       last;
    } res_t;

    res_t       exp_q[$];
    bit         pkt_open;
    logic [2:0] pkt_op;
    logic [7:0] pkt_first;
    logic [7:0] pkt_tail[$];

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x & ~y;
            default: return x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic [2:0] op_i, input logic acc_i, input logic last_i);
        in_valid = v;
        a        = a_i;
        b        = b_i;
        op       = op_i;
        acc      = acc_i;
        in_last  = last_i;
    endtask

    // Packet-level model: beats are collected and the packet is folded when it closes.
    task automatic model_beat(input logic [7:0] a_i, input logic [7:0] b_i,
                              input logic [2:0] op_i, input logic acc_i, input logic last_i);
        logic [7:0] r;
        if (!pkt_open && !acc_i) begin
            exp_q.push_back('{val: ref_op(op_i, a_i, b_i), last: last_i});
        end else begin
            if (!pkt_open) begin
                pkt_open  = 1'b1;
                pkt_op    = op_i;
                pkt_first = ref_op(op_i, a_i, b_i);
                pkt_tail.delete();
            end else begin
                pkt_tail.push_back(a_i);
            end
            if (last_i) begin
                r = pkt_first;
                foreach (pkt_tail[i]) r = ref_op(pkt_op, r, pkt_tail[i]);
                exp_q.push_back('{val: r, last: 1'b1});
                pkt_open = 1'b0;
            end
        end
    endtask

    initial begin
        logic exp_ready;
        res_t r;

        // Reset state
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        check_bit("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 8'h00);
        check_bit("rst_out_last", out_last, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
`ifdef LOGIC_FLAGS_EN
        check_bit("rst_zero", out_zero, 1'b0);
        check_bit("rst_ones", out_ones, 1'b0);
        check_bit("rst_parity", out_parity, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Elementwise back-to-back beats, one result per cycle
        drive(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        tick();
        check("ew_and", out, 8'h30);
        check_bit("ew_and_valid", out_valid, 1'b1);
        check_bit("ew_and_last", out_last, 1'b0);
        op = 3'd1;
        tick();
        check("ew_or", out, 8'hFC);
        check_bit("ew_or_valid", out_valid, 1'b1);
        op = 3'd2;
        tick();
        check("ew_xor", out, 8'hCC);
        op = 3'd6;
        tick();
        check("ew_andn", out, 8'hC0);
        check_bit("ew_andn_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();
        check_bit("ew_drain_valid", out_valid, 1'b0);

        // Accumulate XOR over three beats; OP/ACC changes on later beats are ignored
        drive(1'b1, 8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
        tick();
        check_bit("acc_beat1_no_out", out_valid, 1'b0);
        drive(1'b1, 8'h04, 8'hA5, 3'd0, 1'b0, 1'b0);
        tick();
        check_bit("acc_beat2_no_out", out_valid, 1'b0);
        drive(1'b1, 8'h08, 8'h5A, 3'd0, 1'b0, 1'b1);
        tick();
        check("acc_result", out, 8'h0F);
        check_bit("acc_result_valid", out_valid, 1'b1);
        check_bit("acc_result_last", out_last, 1'b1);
        in_valid = 1'b0;
        tick();
        check_bit("acc_drain_valid", out_valid, 1'b0);

        // Backpressure: result held, input stalled, then same-cycle transfer and accept
        drive(1'b1, 8'hF0, 8'h3C, 3'd1, 1'b0, 1'b0);
        out_ready = 1'b0;
        tick();
        check("bp_first", out, 8'hFC);
        op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_bit("bp_in_ready_low", in_ready, 1'b0);
            tick();
            check("bp_hold_out", out, 8'hFC);
            check_bit("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check_bit("bp_release_ready", in_ready, 1'b1);
        tick();
        check("bp_next", out, 8'h30);
        check_bit("bp_next_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();

        // Single-beat accumulate packet, then prove FSM stayed idle
        drive(1'b1, 8'hFF, 8'h0F, 3'd3, 1'b1, 1'b1);
        tick();
        check("single_out", out, 8'hF0);
        check_bit("single_last", out_last, 1'b1);
        drive(1'b1, 8'h5A, 8'h00, 3'd7, 1'b0, 1'b0);
        tick();
        check("single_then_pass", out, 8'h5A);
        check_bit("single_then_last", out_last, 1'b0);
        in_valid = 1'b0;
        tick();

        // Reset mid-packet discards the partial accumulation
        drive(1'b1, 8'h11, 8'h22, 3'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h44, 8'h00, 3'd2, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_bit("midrst_valid", out_valid, 1'b0);
        check("midrst_out", out, 8'h00);
        rst_n = 1'b1;
        drive(1'b1, 8'h10, 8'h01, 3'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h20, 8'hFF, 3'd2, 1'b1, 1'b1);
        tick();
        check("midrst_new_pkt", out, 8'h31);
        check_bit("midrst_new_last", out_last, 1'b1);
        in_valid = 1'b0;
        tick();

`ifdef LOGIC_FLAGS_EN
        drive(1'b1, 8'hAA, 8'h55, 3'd5, 1'b0, 1'b0);
        tick();
        check("flags_xnor_out", out, 8'h00);
        check_bit("flags_xnor_zero", out_zero, 1'b1);
        check_bit("flags_xnor_ones", out_ones, 1'b0);
        check_bit("flags_xnor_par", out_parity, 1'b0);
        op = 3'd1;
        tick();
        check("flags_or_out", out, 8'hFF);
        check_bit("flags_or_zero", out_zero, 1'b0);
        check_bit("flags_or_ones", out_ones, 1'b1);
        check_bit("flags_or_par", out_parity, 1'b0);
        in_valid = 1'b0;
        tick();
`endif

        // Randomized traffic against the model
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        pkt_open = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                tick();
                rst_n    = 1'b1;
                pkt_open = 1'b0;
                exp_q.delete();
                continue;
            end
            drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (exp_q.size() == 0) || out_ready;
            check_bit("rnd_in_ready", in_ready, exp_ready);
            check_bit("rnd_out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0 && out_ready) begin
                r = exp_q.pop_front();
                check("rnd_out", out, r.val);
                check_bit("rnd_out_last", out_last, r.last);
`ifdef LOGIC_FLAGS_EN
                check_bit("rnd_zero", out_zero, r.val == 8'h00);
                check_bit("rnd_ones", out_ones, r.val == 8'hFF);
                check_bit("rnd_parity", out_parity, ^r.val);
`endif
            end
            if (in_valid && exp_ready) model_beat(a, b, op, acc, in_last);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
